instr_fetch_stage: RTL
======================

Name: instr_fetch_stage

Overview:
Fetch stage and IF/ID pipeline register that supplies the 32-bit instruction word consumed by the main decode controller. It holds the PC and drives the instruction-memory address. It registers the fetched word with its PC+4 and applies stall, bubble and redirect requests from the ID stage (j/jal/jr) and the EX stage (taken branches). An all-zero word is the pipeline bubble because it decodes to all-inactive controls.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
IMEM_ADDR_W, 10, word-address width driven to instruction memory

Ports:
Clk  in  1  clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hazard unit request: hold PC and IF/ID
JumpID  in  1  controller jump_target for the instruction in ID (j/jal)
JrID  in  1  controller jr for the instruction in ID
JrTarget  in  32  rs value forwarded to ID for jr
BranchTakenEX  in  1  branch in EX resolved taken
BranchTargetEX  in  32  branch target computed in EX
ImemAddr  out  IMEM_ADDR_W  word address, equal to PC[IMEM_ADDR_W+1:2]
ImemData  in  32  instruction word; combinational read of ImemAddr
Instruction  out  32  IF/ID instruction, feeds the decode controller
PCPlus4ID  out  32  IF/ID PC+4
ValidID  out  1  IF/ID holds a real fetched instruction
PC  out  32  current fetch PC
MisalignFault  out  1  sticky flag: a redirect target had bits [1:0] != 0
FetchCount  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (synchronous, highest priority), at the clock edge: PC=PC_RESET; Instruction=0; PCPlus4ID=0; ValidID=0; MisalignFault=0; FetchCount=0. A reset asserted during a redirect or stall overrides both.
- Jump target: JumpTgt = {PCPlus4ID[31:28], Instruction[25:0], 2'b00}, formed from the IF/ID register contents.
- Next-PC priority, highest first; all cases below assume Reset is low:
  1. BranchTakenEX: PC <= BranchTargetEX. IF/ID <= bubble (Instruction=0, ValidID=0, PCPlus4ID=0). This also squashes the ID instruction's jump, because the older instruction wins.
  2. JumpID or JrID, with ValidID=1 and Stall=0: PC <= JumpTgt or JrTarget. If both are asserted, JrID wins. IF/ID <= bubble.
  3. Stall: PC and IF/ID hold. FetchCount holds. A jump in ID waits until Stall deasserts.
  4. Normal: PC <= PC+4, wrapping modulo 2^32 from 32'hFFFF_FFFC to 0. IF/ID <= {ImemData, PC+4}. ValidID=1. FetchCount +1 (wraps).
- Redirect alignment: bits [1:0] of any redirect target are forced to 0 before loading PC. If either bit was nonzero, MisalignFault is set and stays set until Reset.
- BranchTakenEX overrides Stall. A redirect with Stall still redirects and bubbles.
- Latency: a word appears on Instruction one cycle after its PC. A taken jump costs 1 bubble; a taken branch costs 1 bubble in IF/ID, and the ID instruction is discarded.
- A fetched word equal to 0 (nop/sll $0) sets ValidID=1 and is counted.
- JumpID and JrID are ignored while ValidID=0, so a bubble's decoded controls never redirect.

Decomposition:
- Shared package holds NOP_WORD=32'h0, PC_STEP=4, and the jump-target field slices (J_INDEX_MSB=25, PC_REGION_MSB=31, PC_REGION_LSB=28).
- One natural sub-module: if_id_reg, the IF/ID register with hold (Stall) and bubble (flush) controls.
- Next-PC selection and the fault/counter logic stay in the top level.

Test Plan:
1. Reset with PC_RESET=0; release; ImemData returns word address ×4. Required: PC 0,4,8 on successive cycles; Instruction lags PC by one cycle; FetchCount=3 after 3 accepted fetches.
2. Stall for 2 cycles at PC=8. Required: PC stays 8, Instruction and FetchCount hold; PC goes to 12 on the first cycle after Stall drops.
3. IF/ID holds j with index 0x0000040 and PCPlus4ID=0x0000_0010, with JumpID=1. Required: next PC=0x0000_0100; Instruction=0, ValidID=0 for one cycle.
4. Same cycle: JrID=1 with JrTarget=0x200, and BranchTakenEX=1 with BranchTargetEX=0x300. Required: PC=0x300, bubble inserted.
5. BranchTargetEX=0x0000_0402 with BranchTakenEX=1. Required: PC=0x400; MisalignFault=1 and stays 1 through 5 normal cycles; cleared only by Reset.
6. Reset asserted while BranchTakenEX=1 at PC=0xFFFF_FFFC. Required: PC=PC_RESET, all outputs at reset values. Separate run without reset: PC=0xFFFF_FFFC advances to PC=0.

Source files
------------

// File: rtl/instr_fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and its IF/ID register.
// Keeps the jump-target field positions and bubble encoding in one place.
package instr_fetch_stage_pkg;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam int          J_INDEX_MSB   = 25;
  localparam int          PC_REGION_MSB = 31;
  localparam int          PC_REGION_LSB = 28;

  // Source of the next PC, listed lowest to highest priority.
  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'd0,
    PCSEL_HOLD   = 2'd1,
    PCSEL_JUMP   = 2'd2,
    PCSEL_BRANCH = 2'd3
  } pcSel_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifId_t;

  localparam ifId_t IFID_BUBBLE = '{instr: NOP_WORD, pcPlus4: 32'h0, valid: 1'b0};

  // Redirect targets are word aligned; the two low bits are simply dropped.
  function automatic logic [31:0] alignTarget(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if_id.sv
// IF/ID pipeline register with hold and flush controls.
// Priority: reset, then flush (bubble), then hold, then load.
module instr_fetch_stage_if_id
  import instr_fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pcPlus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pcPlus4,
  output logic        o_valid
);

  ifId_t r_entry;
  ifId_t w_loadEntry;

  assign w_loadEntry = '{instr: i_instr, pcPlus4: i_pcPlus4, valid: 1'b1};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_entry <= IFID_BUBBLE;
    end else if (i_flush) begin
      r_entry <= IFID_BUBBLE;
    end else if (!i_hold) begin
      r_entry <= w_loadEntry;
    end
  end

  assign o_instr   = r_entry.instr;
  assign o_pcPlus4 = r_entry.pcPlus4;
  assign o_valid   = r_entry.valid;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, next-PC selection, misalignment flag and
// accepted-fetch counter, feeding the IF/ID register.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_stall,
  input  logic                   i_jumpId,
  input  logic                   i_jrId,
  input  logic [31:0]            i_jrTarget,
  input  logic                   i_branchTakenEx,
  input  logic [31:0]            i_branchTargetEx,
  output logic [IMEM_ADDR_W-1:0] o_imemAddr,
  input  logic [31:0]            i_imemData,
  output logic [31:0]            o_instruction,
  output logic [31:0]            o_pcPlus4Id,
  output logic                   o_validId,
  output logic [31:0]            o_pc,
  output logic                   o_misalignFault,
  output logic [31:0]            o_fetchCount
);

  logic [31:0] r_pc;
  logic        r_misalignFault;
  logic [31:0] r_fetchCount;

  logic [31:0] w_idInstr;
  logic [31:0] w_idPcPlus4;
  logic        w_idValid;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_jumpTgt;
  logic        w_takeJump;
  pcSel_t      w_pcSel;
  logic [31:0] w_redirectRaw;
  logic [31:0] w_nextPc;
  logic        w_redirect;
  logic        w_misalign;

  assign w_pcPlus4 = r_pc + PC_STEP;
  assign w_jumpTgt = {w_idPcPlus4[PC_REGION_MSB:PC_REGION_LSB],
                      w_idInstr[J_INDEX_MSB:0], 2'b00};

  // A bubble in ID must never redirect, and a stalled jump waits its turn.
  assign w_takeJump = (i_jumpId || i_jrId) && w_idValid && !i_stall;

  always_comb begin
    w_pcSel = PCSEL_SEQ;
    if (i_branchTakenEx) begin
      w_pcSel = PCSEL_BRANCH;
    end else if (w_takeJump) begin
      w_pcSel = PCSEL_JUMP;
    end else if (i_stall) begin
      w_pcSel = PCSEL_HOLD;
    end
  end

  always_comb begin
    w_redirectRaw = w_jumpTgt;
    if (w_pcSel == PCSEL_BRANCH) begin
      w_redirectRaw = i_branchTargetEx;
    end else if (i_jrId) begin
      w_redirectRaw = i_jrTarget;
    end
  end

  assign w_redirect = (w_pcSel == PCSEL_BRANCH) || (w_pcSel == PCSEL_JUMP);
  assign w_misalign = w_redirect && (w_redirectRaw[1:0] != 2'b00);

  always_comb begin
    w_nextPc = w_pcPlus4;
    case (w_pcSel)
      PCSEL_BRANCH,
      PCSEL_JUMP:   w_nextPc = alignTarget(w_redirectRaw);
      PCSEL_HOLD:   w_nextPc = r_pc;
      default:      w_nextPc = w_pcPlus4;
    endcase
  end

  // The fault flag is sticky until reset; the counter tracks IF/ID loads only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc            <= PC_RESET;
      r_misalignFault <= 1'b0;
      r_fetchCount    <= 32'h0;
    end else begin
      r_pc <= w_nextPc;
      if (w_misalign) begin
        r_misalignFault <= 1'b1;
      end
      if (w_pcSel == PCSEL_SEQ) begin
        r_fetchCount <= r_fetchCount + 32'd1;
      end
    end
  end

  instr_fetch_stage_if_id u_ifId (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_hold    (w_pcSel == PCSEL_HOLD),
    .i_flush   (w_redirect),
    .i_instr   (i_imemData),
    .i_pcPlus4 (w_pcPlus4),
    .o_instr   (w_idInstr),
    .o_pcPlus4 (w_idPcPlus4),
    .o_valid   (w_idValid)
  );

  assign o_imemAddr      = r_pc[IMEM_ADDR_W+1:2];
  assign o_instruction   = w_idInstr;
  assign o_pcPlus4Id     = w_idPcPlus4;
  assign o_validId       = w_idValid;
  assign o_pc            = r_pc;
  assign o_misalignFault = r_misalignFault;
  assign o_fetchCount    = r_fetchCount;

endmodule
